// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

  // Per-channel filter states; the MSB doubles as the debounced level.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_value, never less than one bit.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability filter FSM, hold counter
// and registered one-cycle event pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic button,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int SW = cnt_width(STABLE_TICKS);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [SW-1:0]          cnt;
  logic [SW-1:0]          cnt_inc;
  logic                   fall_now;

  // Shift the raw level through the synchroniser every clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], button};
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt + SW'(1);

  // Flags the tick on which the debounced level is about to drop.
  always_comb begin
    fall_now = 1'b0;
    if (sample_tick && !s) begin
      if (state == HELD && STABLE_TICKS == 1)                 fall_now = 1'b1;
      else if (state == RELEASING && cnt_inc == STABLE_MAX)   fall_now = 1'b1;
    end
  end

  // Stability filter: the level flips only after enough agreeing ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      debounced <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (s) begin
              if (STABLE_TICKS == 1) begin
                state     <= HELD;
                debounced <= 1'b1;
                rise      <= 1'b1;
                cnt       <= '0;
              end else begin
                state <= ARMING;
                cnt   <= SW'(1);
              end
            end
          end
          ARMING: begin
            if (!s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt_inc == STABLE_MAX) begin
              state     <= HELD;
              debounced <= 1'b1;
              rise      <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HELD: begin
            if (!s) begin
              if (STABLE_TICKS == 1) begin
                state     <= IDLE;
                debounced <= 1'b0;
                fall      <= 1'b1;
                cnt       <= '0;
              end else begin
                state <= RELEASING;
                cnt   <= SW'(1);
              end
            end
          end
          RELEASING: begin
            if (s) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt_inc == STABLE_MAX) begin
              state     <= IDLE;
              debounced <= 1'b0;
              fall      <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  if (LONG_TICKS > 0) begin : g_long
    localparam int HW = cnt_width(LONG_TICKS);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_TICKS);
    logic [HW-1:0] hold;

    // Count ticks spent high after the rise; pulse once when the limit is hit.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold       <= '0;
        long_press <= 1'b0;
      end else begin
        long_press <= 1'b0;
        if (sample_tick) begin
          if (!debounced || fall_now) begin
            hold <= '0;
          end else if (hold != LONG_MAX) begin
            hold <= hold + HW'(1);
            if (hold + HW'(1) == LONG_MAX) long_press <= 1'b1;
          end
        end
      end
    end
  end else begin : g_no_long
    assign long_press = 1'b0;
  end

endmodule

// File: rtl/debounce_array.sv
// Multi-channel push-button debouncer: shared sample prescaler feeding
// independent per-channel filters.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 1,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_debounced,
  output logic [CHANNELS-1:0] button_rise,
  output logic [CHANNELS-1:0] button_fall,
  output logic [CHANNELS-1:0] button_long,
  output logic                sample_tick
);

  localparam int PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_cnt;
  logic [PW-1:0] div_next;

  assign div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + PW'(1);

  // Prescaler; the tick is registered so it is clean and low during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      sample_tick <= (div_next == DIV_LAST);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .sample_tick(sample_tick),
      .button     (button[i]),
      .debounced  (button_debounced[i]),
      .rise       (button_rise[i]),
      .fall       (button_fall[i]),
      .long_press (button_long[i])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array: a fast 4-channel instance and a
// prescaled 2-channel instance with long-press enabled.
module tb_debounce_array;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button_a;
  logic [3:0] deb_a, rise_a, fall_a, long_a;
  logic       tick_a;
  logic [1:0] button_b;
  logic [1:0] deb_b, rise_b, fall_b, long_b;
  logic       tick_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debounce_array #(
    .CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4), .LONG_TICKS(0)
  ) dut_a (
    .clk(clk), .reset(reset), .button(button_a),
    .button_debounced(deb_a), .button_rise(rise_a), .button_fall(fall_a),
    .button_long(long_a), .sample_tick(tick_a)
  );

  debounce_array #(
    .CHANNELS(2), .SYNC_STAGES(2), .TICK_DIV(5), .STABLE_TICKS(2), .LONG_TICKS(8)
  ) dut_b (
    .clk(clk), .reset(reset), .button(button_b),
    .button_debounced(deb_b), .button_rise(rise_b), .button_fall(fall_b),
    .button_long(long_b), .sample_tick(tick_b)
  );

  // Everything cleared while reset is low; tick starts right after release.
  task automatic test_reset();
    reset = 1'b0; button_a = '0; button_b = '0;
    repeat (2) @(negedge clk);
    n_checks++; if ({deb_a, rise_a, fall_a, long_a} !== 16'h0) $display("[TB] FAIL reset_outs_a: got %h expected 0000", {deb_a, rise_a, fall_a, long_a}); else n_pass++;
    n_checks++; if ({deb_b, rise_b, fall_b, long_b} !== 8'h0) $display("[TB] FAIL reset_outs_b: got %h expected 00", {deb_b, rise_b, fall_b, long_b}); else n_pass++;
    n_checks++; if ({tick_a, tick_b} !== 2'b00) $display("[TB] FAIL reset_ticks: got %b expected 00", {tick_a, tick_b}); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (tick_a !== 1'b1) $display("[TB] FAIL tick_a_after_reset: got %b expected 1", tick_a); else n_pass++;
    n_checks++; if (tick_b !== 1'b0) $display("[TB] FAIL tick_b_after_reset: got %b expected 0", tick_b); else n_pass++;
  endtask

  // Channel 0 pressed cleanly: level and rise land on edge 6.
  task automatic test_clean_press();
    logic [3:0] exp_deb, exp_rise;
    button_a[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_deb  = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_rise = (e == 6) ? 4'b0001 : 4'b0000;
      n_checks++; if (deb_a !== exp_deb) $display("[TB] FAIL press_deb e%0d: got %b expected %b", e, deb_a, exp_deb); else n_pass++;
      n_checks++; if (rise_a !== exp_rise) $display("[TB] FAIL press_rise e%0d: got %b expected %b", e, rise_a, exp_rise); else n_pass++;
    end
  endtask

  // Channel 1 bounces with 3-cycle runs; only the final settle produces a rise.
  task automatic test_bounce();
    logic [3:0] exp_deb, exp_rise;
    for (int c = 0; c < 30; c++) begin
      button_a[1] = ((c / 3) % 2 == 0);
      @(negedge clk);
      n_checks++; if ({deb_a, rise_a} !== 8'b0001_0000) $display("[TB] FAIL bounce_quiet c%0d: got %b expected 00010000", c, {deb_a, rise_a}); else n_pass++;
    end
    button_a[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_deb  = (e >= 6) ? 4'b0011 : 4'b0001;
      exp_rise = (e == 6) ? 4'b0010 : 4'b0000;
      n_checks++; if ({deb_a, rise_a} !== {exp_deb, exp_rise}) $display("[TB] FAIL bounce_settle e%0d: got %b expected %b", e, {deb_a, rise_a}, {exp_deb, exp_rise}); else n_pass++;
    end
  endtask

  // Short release glitch is swallowed; a sustained release gives one fall.
  task automatic test_release_glitch();
    logic [3:0] exp_deb, exp_fall;
    for (int c = 0; c < 10; c++) begin
      button_a[0] = (c >= 2);
      @(negedge clk);
      n_checks++; if ({deb_a, fall_a} !== 8'b0011_0000) $display("[TB] FAIL glitch_hold c%0d: got %b expected 00110000", c, {deb_a, fall_a}); else n_pass++;
    end
    button_a[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_deb  = (e >= 6) ? 4'b0010 : 4'b0011;
      exp_fall = (e == 6) ? 4'b0001 : 4'b0000;
      n_checks++; if ({deb_a, fall_a} !== {exp_deb, exp_fall}) $display("[TB] FAIL release e%0d: got %b expected %b", e, {deb_a, fall_a}, {exp_deb, exp_fall}); else n_pass++;
    end
  endtask

  // Two channels pressed together rise in the same cycle.
  task automatic test_simultaneous();
    logic [3:0] exp_deb, exp_rise;
    button_a[3:2] = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_deb  = (e >= 6) ? 4'b1110 : 4'b0010;
      exp_rise = (e == 6) ? 4'b1100 : 4'b0000;
      n_checks++; if ({deb_a, rise_a, fall_a} !== {exp_deb, exp_rise, 4'b0000}) $display("[TB] FAIL simul e%0d: got %b expected %b", e, {deb_a, rise_a, fall_a}, {exp_deb, exp_rise, 4'b0000}); else n_pass++;
    end
  endtask

  // Prescaled instance ticks once every 5 cycles.
  task automatic test_prescaler();
    logic exp_tick;
    for (int k = 0; k < 10 && !tick_b; k++) @(negedge clk);
    n_checks++; if (tick_b !== 1'b1) $display("[TB] FAIL tick_b_found: got %b expected 1", tick_b); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_tick = (k % 5 == 0);
      n_checks++; if (tick_b !== exp_tick) $display("[TB] FAIL tick_b_period k%0d: got %b expected %b", k, tick_b, exp_tick); else n_pass++;
    end
  endtask

  // Held button: exactly one long pulse 40 cycles (8 ticks) after the rise.
  task automatic test_long_press();
    bit found = 0;
    int first_long = -1, long_count = 0, other = 0;
    button_b[0] = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (rise_b[0]) found = 1;
    end
    n_checks++; if (found !== 1'b1) $display("[TB] FAIL long_rise_seen: got %b expected 1", found); else n_pass++;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (long_b[0]) begin long_count++; if (first_long < 0) first_long = k; end
      if (long_b[1]) other++;
    end
    n_checks++; if (first_long != 40) $display("[TB] FAIL long_delay: got %0d expected 40", first_long); else n_pass++;
    n_checks++; if (long_count != 1) $display("[TB] FAIL long_count: got %0d expected 1", long_count); else n_pass++;
    n_checks++; if (other != 0) $display("[TB] FAIL long_other_chan: got %0d expected 0", other); else n_pass++;
    n_checks++; if (deb_b !== 2'b01) $display("[TB] FAIL long_deb: got %b expected 01", deb_b); else n_pass++;
    button_b[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (fall_b[0]) found = 1;
    end
    n_checks++; if (found !== 1'b1) $display("[TB] FAIL long_fall_seen: got %b expected 1", found); else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  // Debounced level drops on tick 7 after the rise, so no long pulse.
  task automatic test_release_before_long();
    bit found = 0;
    int first_fall = -1, long_count = 0;
    button_b[0] = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (rise_b[0]) found = 1;
    end
    n_checks++; if (found !== 1'b1) $display("[TB] FAIL early_rise_seen: got %b expected 1", found); else n_pass++;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (fall_b[0] && first_fall < 0) first_fall = k;
      if (long_b[0]) long_count++;
      if (k == 26) button_b[0] = 1'b0;
    end
    n_checks++; if (first_fall != 35) $display("[TB] FAIL early_fall_time: got %0d expected 35", first_fall); else n_pass++;
    n_checks++; if (long_count != 0) $display("[TB] FAIL early_no_long: got %0d expected 0", long_count); else n_pass++;
    n_checks++; if (deb_b !== 2'b00) $display("[TB] FAIL early_deb: got %b expected 00", deb_b); else n_pass++;
  endtask

  // Reset during ARMING and HELD clears outputs at once; held buttons re-rise.
  task automatic test_reset_mid();
    bit found = 0;
    int first_rise_b = -1, b_rises = 0, bad_fall = 0;
    logic [3:0] exp_deb, exp_rise;
    button_b[0] = 1'b1;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (rise_b[0]) found = 1;
    end
    n_checks++; if (found !== 1'b1) $display("[TB] FAIL mid_b_rise_seen: got %b expected 1", found); else n_pass++;
    button_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if ({deb_a, rise_a, fall_a} !== 12'h000) $display("[TB] FAIL mid_reset_a: got %h expected 000", {deb_a, rise_a, fall_a}); else n_pass++;
    n_checks++; if ({deb_b, rise_b, fall_b, long_b} !== 8'h00) $display("[TB] FAIL mid_reset_b: got %h expected 00", {deb_b, rise_b, fall_b, long_b}); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++; if ({deb_a, rise_a, fall_a, deb_b, rise_b, fall_b, long_b, tick_a, tick_b} !== 22'h0) $display("[TB] FAIL mid_reset_hold k%0d: got %h expected 0", k, {deb_a, rise_a, fall_a, deb_b, rise_b, fall_b, long_b, tick_a, tick_b}); else n_pass++;
    end
    reset = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (e <= 8) begin
        exp_deb  = (e >= 6) ? 4'b1111 : 4'b0000;
        exp_rise = (e == 6) ? 4'b1111 : 4'b0000;
        n_checks++; if ({deb_a, rise_a} !== {exp_deb, exp_rise}) $display("[TB] FAIL rerise_a e%0d: got %b expected %b", e, {deb_a, rise_a}, {exp_deb, exp_rise}); else n_pass++;
      end
      if (rise_b[0]) begin b_rises++; if (first_rise_b < 0) first_rise_b = e; end
      if (fall_a !== 4'b0000 || fall_b !== 2'b00) bad_fall++;
    end
    n_checks++; if (first_rise_b != 10) $display("[TB] FAIL rerise_b_time: got %0d expected 10", first_rise_b); else n_pass++;
    n_checks++; if (b_rises != 1) $display("[TB] FAIL rerise_b_count: got %0d expected 1", b_rises); else n_pass++;
    n_checks++; if (bad_fall != 0) $display("[TB] FAIL rerise_no_fall: got %0d expected 0", bad_fall); else n_pass++;
    n_checks++; if (deb_b !== 2'b01) $display("[TB] FAIL rerise_b_deb: got %b expected 01", deb_b); else n_pass++;
  endtask

  // Runs the scenarios in order and prints the summary.
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_prescaler();
    test_long_press();
    test_release_before_long();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case the scenario sequence stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
